power_domain_sequencer: RTL and testbench

- Shares one gated clock domain among NUM_REQ requesters.
- Aggregates requests and drives the clock-gate enable, completing the start and stop handshakes against gate feedback.
- Holds the domain on for an idle hysteresis window and grants per-requester acknowledges only while the clock is running.
- Sits above a power node, between client blocks and the clock-gate cell.

---
 rtl/power_domain_sequencer.sv | 114 +++++++++++
 tb/tb_power_domain_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/power_domain_sequencer.sv
// Shares one gated clock domain among NUM_REQ requesters: start/stop handshakes
// against gate feedback, idle hysteresis, and per-requester acknowledges.
module power_domain_sequencer #(
  parameter int NUM_REQ       = 4,
  parameter int IDLE_HOLD     = 8,
  parameter int START_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic                             clock,
  input  logic                             async_resetn,
  input  logic [NUM_REQ-1:0]               req,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             clk_en,
  input  logic                             clk_on,
  output logic                             domain_ready,
  output logic                             domain_stopping,
  output logic                             start_timeout_err,
  input  logic                             err_clear,
  output logic [$clog2(NUM_REQ+1)-1:0]     active_count,
  output logic [2:0]                       dbg_state
);

  localparam int AC_W = $clog2(NUM_REQ+1);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_STARTING  = 3'd1,
    ST_ON        = 3'd2,
    ST_IDLE_WAIT = 3'd3,
    ST_STOPPING  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic [AC_W-1:0]   count_q, count_d;
  logic              any_req;

  assign any_req = |req;
  // The counter parks at all-ones whenever no state is timing anything.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    err_d   = err_q;
    if (err_clear) err_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (any_req && !err_q) begin
          state_d = ST_STARTING;
          cnt_d   = '0;
        end
      end
      ST_STARTING: begin
        if (clk_on) begin
          state_d = ST_ON;
        end else if (cnt_q == CNT_W'(START_TIMEOUT-1)) begin
          state_d = ST_STOPPING;
          err_d   = 1'b1;
        end
      end
      ST_ON: begin
        if (!any_req) begin
          state_d = ST_IDLE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_IDLE_WAIT: begin
        if (any_req) begin
          state_d = ST_ON;
        end else if (cnt_q == CNT_W'(IDLE_HOLD-1)) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (!clk_on) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      count_d = count_d + AC_W'(ack[i]);
    end
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Control outputs decode only the registered state so they cannot glitch.
  assign clk_en            = (state_q == ST_STARTING) || (state_q == ST_ON) ||
                             (state_q == ST_IDLE_WAIT);
  assign domain_ready      = (state_q == ST_ON) || (state_q == ST_IDLE_WAIT);
  assign domain_stopping   = (state_q == ST_STOPPING);
  assign ack               = req & {NUM_REQ{domain_ready}};
  assign start_timeout_err = err_q;
  assign active_count      = count_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_power_domain_sequencer;

  localparam int W = 14;
  localparam logic [2:0] S_OFF = 3'd0, S_STA = 3'd1, S_ON = 3'd2,
                         S_IDL = 3'd3, S_STP = 3'd4;

  logic       clock = 1'b0;
  logic       async_resetn;
  logic [3:0] req;
  logic [3:0] ack;
  logic       clk_en, clk_on, domain_ready, domain_stopping;
  logic       start_timeout_err, err_clear;
  logic [2:0] active_count, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_name_q[$];

  power_domain_sequencer dut (
    .clock             (clock),
    .async_resetn      (async_resetn),
    .req               (req),
    .ack               (ack),
    .clk_en            (clk_en),
    .clk_on            (clk_on),
    .domain_ready      (domain_ready),
    .domain_stopping   (domain_stopping),
    .start_timeout_err (start_timeout_err),
    .err_clear         (err_clear),
    .active_count      (active_count),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input logic [3:0] r, input logic on, input logic clr);
    @(posedge clock);
    #1;
    req       = r;
    clk_on    = on;
    err_clear = clr;
  endtask

  task automatic expect_v(input string name, input logic [2:0] st, input logic en,
                          input logic [3:0] a, input logic rdy, input logic stp,
                          input logic err, input logic [2:0] cnt);
    exp_q.push_back({st, en, a, rdy, stp, err, cnt});
    exp_cyc_q.push_back(cyc);
    exp_name_q.push_back(name);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W-1:0] got, want;
    string        nm;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      void'(exp_cyc_q.pop_front());
      want = exp_q.pop_front();
      nm   = exp_name_q.pop_front();
      got  = {dbg_state, clk_en, ack, domain_ready, domain_stopping,
              start_timeout_err, active_count};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %b required %b (state,en,ack,rdy,stp,err,cnt)",
                 nm, cyc, got, want);
      end
    end
  end

  initial begin
    async_resetn = 1'b0;
    req          = 4'b0000;
    clk_on       = 1'b0;
    err_clear    = 1'b0;

    // reset state
    step(4'b0000, 1'b0, 1'b0); expect_v("reset",     S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0000, 1'b0, 1'b0); expect_v("reset2",    S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    @(posedge clock); #1 async_resetn = 1'b1;
    expect_v("rst_rel", S_OFF, 0, 4'b0000, 0, 0, 0, 0);

    // basic start, clk_on rises 3 cycles after clk_en
    step(4'b0001, 1'b0, 1'b0); expect_v("s1_off",    S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b0, 1'b0); expect_v("s1_start",  S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b0, 1'b0); expect_v("s1_start",  S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b0, 1'b0); expect_v("s1_start",  S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_v("s1_pre_on", S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_v("s1_on",     S_ON,  1, 4'b0001, 1, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_v("s1_count",  S_ON,  1, 4'b0001, 1, 0, 0, 1);

    // idle hysteresis: exactly 8 idle cycles, then stop
    step(4'b0000, 1'b1, 1'b0); expect_v("s2_drop",   S_ON,  1, 4'b0000, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b1, 1'b0); expect_v("s2_idle", S_IDL, 1, 4'b0000, 1, 0, 0, 0);
    end
    step(4'b0000, 1'b1, 1'b0); expect_v("s2_stop",   S_STP, 0, 4'b0000, 0, 1, 0, 0);
    step(4'b0000, 1'b0, 1'b0); expect_v("s2_stopw",  S_STP, 0, 4'b0000, 0, 1, 0, 0);
    step(4'b0000, 1'b0, 1'b0); expect_v("s2_off",    S_OFF, 0, 4'b0000, 0, 0, 0, 0);

    // bring back up, re-request at idle cycle 5
    step(4'b0001, 1'b0, 1'b0); expect_v("s2_off2",   S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_v("s2_sta",    S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_v("s2_on",     S_ON,  1, 4'b0001, 1, 0, 0, 0);
    step(4'b0000, 1'b1, 1'b0); expect_v("s2_drop2",  S_ON,  1, 4'b0000, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 1'b1, 1'b0); expect_v("s2_idle2", S_IDL, 1, 4'b0000, 1, 0, 0, 0);
    end
    step(4'b0001, 1'b1, 1'b0); expect_v("s2_rereq", S_IDL, 1, 4'b0001, 1, 0, 0, 0);
    step(4'b0001, 1'b1, 1'b0); expect_v("s2_backon", S_ON, 1, 4'b0001, 1, 0, 0, 1);

    // multi-requester tracking with one-cycle active_count lag
    step(4'b0011, 1'b1, 1'b0); expect_v("s3_0011",   S_ON,  1, 4'b0011, 1, 0, 0, 1);
    step(4'b0010, 1'b1, 1'b0); expect_v("s3_0010",   S_ON,  1, 4'b0010, 1, 0, 0, 2);
    step(4'b0000, 1'b1, 1'b0); expect_v("s3_0000",   S_ON,  1, 4'b0000, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b1, 1'b0); expect_v("s3_idle", S_IDL, 1, 4'b0000, 1, 0, 0, 0);
    end

    // stop race: request during STOPPING while clk_on still high
    step(4'b0011, 1'b1, 1'b0); expect_v("s5_stp",    S_STP, 0, 4'b0000, 0, 1, 0, 0);
    step(4'b0011, 1'b1, 1'b0); expect_v("s5_stp",    S_STP, 0, 4'b0000, 0, 1, 0, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s5_stpw",   S_STP, 0, 4'b0000, 0, 1, 0, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s5_off",    S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s5_sta",    S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 1'b1, 1'b0); expect_v("s5_sta2",   S_STA, 1, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 1'b1, 1'b0); expect_v("s5_on",     S_ON,  1, 4'b0011, 1, 0, 0, 0);
    step(4'b0011, 1'b1, 1'b0); expect_v("s5_cnt",    S_ON,  1, 4'b0011, 1, 0, 0, 2);

    // async reset mid-ON: outputs clear before the next clock edge
    @(posedge clock); #1 async_resetn = 1'b0;
    expect_v("s6_async", S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    #1;
    n_checks++;
    if ({clk_en, ack, domain_ready, domain_stopping, active_count} !== 10'b0) begin
      n_fail++;
      $display("FAIL s6_immediate: got en=%b ack=%b rdy=%b stp=%b cnt=%0d required all 0",
               clk_en, ack, domain_ready, domain_stopping, active_count);
    end
    step(4'b0011, 1'b1, 1'b0); expect_v("s6_hold",   S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    @(posedge clock); #1 async_resetn = 1'b1; clk_on = 1'b0;
    expect_v("s6_rel", S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s6_restart", S_STA, 1, 4'b0000, 0, 0, 0, 0);

    // start timeout: 64 STARTING cycles total with clk_on stuck low
    for (int i = 0; i < 63; i++) begin
      step(4'b0011, 1'b0, 1'b0); expect_v("s4_sta",  S_STA, 1, 4'b0000, 0, 0, 0, 0);
    end
    step(4'b0011, 1'b0, 1'b0); expect_v("s4_err",    S_STP, 0, 4'b0000, 0, 1, 1, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s4_off",    S_OFF, 0, 4'b0000, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 1'b0, 1'b0); expect_v("s4_hold", S_OFF, 0, 4'b0000, 0, 0, 1, 0);
    end
    step(4'b0011, 1'b0, 1'b1); expect_v("s4_clrp",   S_OFF, 0, 4'b0000, 0, 0, 1, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s4_clrd",   S_OFF, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 1'b0, 1'b0); expect_v("s4_resta",  S_STA, 1, 4'b0000, 0, 0, 0, 0);

    // final report
    repeat (3) @(posedge clock);
    #1;
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no sample required a check at cyc %0d",
               exp_name_q.pop_front(), exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    if (n_fail == 0 && n_checks > 0) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d of %0d checks failed", n_fail, n_checks);
    end
    $finish;
  end

endmodule
